// File: rtl/stq_commit_drain_pkg.sv
// -----------------------------------------------------------------------------
// stq_commit_drain_pkg
// Shared LSU definitions for the store-queue commit drain path: queue geometry,
// commit width, store request payload, size codes and the fence FSM states.
// -----------------------------------------------------------------------------
package stq_commit_drain_pkg;

  localparam int COMMIT_WIDTH = 4;
  localparam int SIZE_LSQ     = 32;
  localparam int SIZE_LSQ_LOG = 5;
  localparam int ADDR_WIDTH   = 32;
  localparam int DATA_WIDTH   = 64;
  // Pending counter width: must hold SIZE_LSQ itself
  localparam int CNT_W        = SIZE_LSQ_LOG + 1;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } st_size_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data;
    st_size_e                size;
    logic [SIZE_LSQ_LOG-1:0] index;
  } store_req_t;

  typedef enum logic {
    DRAIN_IDLE  = 1'b0,
    DRAIN_FENCE = 1'b1
  } drain_state_e;

  // True when committed-but-unwritten stores (counter plus the occupied output
  // stage) exceed the queue capacity. One extra bit keeps the sum from wrapping.
  function automatic logic over_capacity(input logic [CNT_W-1:0] pend,
                                         input logic             stage_valid);
    logic [CNT_W:0] total;
    total = {1'b0, pend} + {{CNT_W{1'b0}}, stage_valid};
    return (total > (CNT_W+1)'(SIZE_LSQ));
  endfunction

endpackage

// File: rtl/stq_commit_drain_pipe_reg.sv
// -----------------------------------------------------------------------------
// lsu_pipe_reg
// Single-entry valid/ready register stage holding a store_req_t.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   in_valid_i        upstream has an entry to offer
//   in_ready_o        stage can take an entry this cycle (empty or draining)
//   in_data_i         upstream payload
//   load_o            entry captured this cycle (in_valid_i && in_ready_o)
//   out_valid_o       stage holds an entry (registered only)
//   out_ready_i       downstream accepts
//   out_fire_o        handshake this cycle
//   out_data_o        held payload
//   valid_next_o      valid value for the next cycle
// -----------------------------------------------------------------------------
module lsu_pipe_reg
  import stq_commit_drain_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  store_req_t in_data_i,
  output logic       load_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       out_fire_o,
  output store_req_t out_data_o,
  output logic       valid_next_o
);

  logic       valid_q, valid_d;
  store_req_t data_q, data_d;
  logic       fire_s, load_s;

  assign fire_s       = valid_q & out_ready_i;
  assign in_ready_o   = ~valid_q | out_ready_i;
  assign load_s       = in_valid_i & (~valid_q | out_ready_i);
  assign load_o       = load_s;
  assign out_fire_o   = fire_s;
  assign out_valid_o  = valid_q;
  assign out_data_o   = data_q;
  assign valid_next_o = valid_d;

  // Next-state for the stage: a load refills it, a lone accept empties it
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_s) begin
      valid_d = 1'b1;
      data_d  = in_data_i;
    end else if (fire_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Stage registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/stq_commit_drain.sv
// -----------------------------------------------------------------------------
// stq_commit_drain
// Drains committed stores from the STQ head to the L1 D-cache, one per cycle,
// in program order, and completes fences once older stores have drained.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   commitStCount_i             stores retired this cycle (0..COMMIT_WIDTH)
//   stqRdIndex_o                STQ head read pointer
//   stqRdAddr/Data/Size_i       combinational read of entry stqRdIndex_o
//   dcStValid_o / dcStReady_i   D-cache store request handshake
//   dcStAddr/Data/Size_o        request payload
//   stqFree_o, stqFreeIndex_o   entry freed on handshake
//   pendingCount_o              committed stores not yet in the output stage
//   fenceReq_i / fenceDone_o    fence request pulse / completion pulse
//   drainOverflow_o             sticky: more committed stores than STQ entries
// -----------------------------------------------------------------------------
module stq_commit_drain
  import stq_commit_drain_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              commitStCount_i,
  output logic [SIZE_LSQ_LOG-1:0] stqRdIndex_o,
  input  logic [ADDR_WIDTH-1:0]   stqRdAddr_i,
  input  logic [DATA_WIDTH-1:0]   stqRdData_i,
  input  logic [1:0]              stqRdSize_i,
  output logic                    dcStValid_o,
  input  logic                    dcStReady_i,
  output logic [ADDR_WIDTH-1:0]   dcStAddr_o,
  output logic [DATA_WIDTH-1:0]   dcStData_o,
  output logic [1:0]              dcStSize_o,
  output logic                    stqFree_o,
  output logic [SIZE_LSQ_LOG-1:0] stqFreeIndex_o,
  output logic [SIZE_LSQ_LOG:0]   pendingCount_o,
  input  logic                    fenceReq_i,
  output logic                    fenceDone_o,
  output logic                    drainOverflow_o
);

  logic [CNT_W-1:0]        pend_q, pend_d;
  logic [SIZE_LSQ_LOG-1:0] rd_ptr_q, rd_ptr_d;
  logic                    ovf_q, ovf_d;
  drain_state_e            state_q, state_d;

  logic       has_pend_s, in_ready_s, load_s, fire_s, valid_s, valid_next_s;
  logic       fence_done_s;
  store_req_t head_req_s, out_req_s;

  assign has_pend_s = (pend_q != {CNT_W{1'b0}});

  assign head_req_s.addr  = stqRdAddr_i;
  assign head_req_s.data  = stqRdData_i;
  assign head_req_s.size  = st_size_e'(stqRdSize_i);
  assign head_req_s.index = rd_ptr_q;

  lsu_pipe_reg u_out_stage (
    .clk          (clk),
    .reset        (reset),
    .in_valid_i   (has_pend_s),
    .in_ready_o   (in_ready_s),
    .in_data_i    (head_req_s),
    .load_o       (load_s),
    .out_valid_o  (valid_s),
    .out_ready_i  (dcStReady_i),
    .out_fire_o   (fire_s),
    .out_data_o   (out_req_s),
    .valid_next_o (valid_next_s)
  );

  assign stqRdIndex_o    = rd_ptr_q;
  assign dcStValid_o     = valid_s;
  assign dcStAddr_o      = out_req_s.addr;
  assign dcStData_o      = out_req_s.data;
  assign dcStSize_o      = out_req_s.size;
  assign stqFree_o       = fire_s;
  assign stqFreeIndex_o  = out_req_s.index;
  assign pendingCount_o  = pend_q;
  assign drainOverflow_o = ovf_q;
  assign fenceDone_o     = fence_done_s;

  // Counter, pointer and overflow next-state; commit and load both apply
  always_comb begin
    pend_d   = pend_q + CNT_W'(commitStCount_i) - CNT_W'(load_s);
    rd_ptr_d = rd_ptr_q;
    if (load_s) begin
      // natural wrap of the power-of-two pointer (31 -> 0)
      rd_ptr_d = rd_ptr_q + {{(SIZE_LSQ_LOG-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    ovf_d = ovf_q | over_capacity(pend_d, valid_next_s);
  end

  // Fence FSM: done once nothing is pending, staged, or arriving this cycle
  always_comb begin
    state_d      = state_q;
    fence_done_s = 1'b0;
    case (state_q)
      DRAIN_IDLE: begin
        if (fenceReq_i) begin
          state_d = DRAIN_FENCE;
        end else begin
          state_d = DRAIN_IDLE;
        end
      end
      DRAIN_FENCE: begin
        fence_done_s = ~has_pend_s & ~valid_s & (commitStCount_i == 3'd0);
        if (fence_done_s) begin
          state_d = DRAIN_IDLE;
        end else begin
          state_d = DRAIN_FENCE;
        end
      end
      default: begin
        state_d = DRAIN_IDLE;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q   <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      state_q  <= DRAIN_IDLE;
    end else begin
      pend_q   <= pend_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_stq_commit_drain.sv
// -----------------------------------------------------------------------------
// tb_stq_commit_drain
// Scoreboard bench: each committed store pushes its expected STQ index; every
// D-cache handshake pops one and checks index, payload and free signals.
// -----------------------------------------------------------------------------
module tb_stq_commit_drain;

  logic        clk;
  logic        reset;
  logic [2:0]  commitStCount_i;
  logic [4:0]  stqRdIndex_o;
  logic [31:0] stqRdAddr_i;
  logic [63:0] stqRdData_i;
  logic [1:0]  stqRdSize_i;
  logic        dcStValid_o;
  logic        dcStReady_i;
  logic [31:0] dcStAddr_o;
  logic [63:0] dcStData_o;
  logic [1:0]  dcStSize_o;
  logic        stqFree_o;
  logic [4:0]  stqFreeIndex_o;
  logic [5:0]  pendingCount_o;
  logic        fenceReq_i;
  logic        fenceDone_o;
  logic        drainOverflow_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [4:0] sb_q[$];
  logic [4:0] w_ptr;
  logic [4:0] exp_idx;

  stq_commit_drain dut (
    .clk             (clk),
    .reset           (reset),
    .commitStCount_i (commitStCount_i),
    .stqRdIndex_o    (stqRdIndex_o),
    .stqRdAddr_i     (stqRdAddr_i),
    .stqRdData_i     (stqRdData_i),
    .stqRdSize_i     (stqRdSize_i),
    .dcStValid_o     (dcStValid_o),
    .dcStReady_i     (dcStReady_i),
    .dcStAddr_o      (dcStAddr_o),
    .dcStData_o      (dcStData_o),
    .dcStSize_o      (dcStSize_o),
    .stqFree_o       (stqFree_o),
    .stqFreeIndex_o  (stqFreeIndex_o),
    .pendingCount_o  (pendingCount_o),
    .fenceReq_i      (fenceReq_i),
    .fenceDone_o     (fenceDone_o),
    .drainOverflow_o (drainOverflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // STQ contents are a fixed function of the entry index
  function automatic logic [31:0] ent_addr(input logic [4:0] i);
    return 32'h8000_0000 + {25'd0, i, 2'd0} * 32'd4;
  endfunction
  function automatic logic [63:0] ent_data(input logic [4:0] i);
    return {27'h5A5A_5A5, i, ~{27'd0, i}};
  endfunction
  function automatic logic [1:0] ent_size(input logic [4:0] i);
    return i[1:0] ^ i[3:2];
  endfunction

  assign stqRdAddr_i = ent_addr(stqRdIndex_o);
  assign stqRdData_i = ent_data(stqRdIndex_o);
  assign stqRdSize_i = ent_size(stqRdIndex_o);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every handshake must match the oldest committed store
  always @(negedge clk) begin
    if (reset) begin
      if (dcStValid_o && dcStReady_i) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_accept", 64'd1, 64'd0);
        end else begin
          exp_idx = sb_q.pop_front();
          check("req_index", {59'd0, stqFreeIndex_o}, {59'd0, exp_idx});
          check("req_addr", {32'd0, dcStAddr_o}, {32'd0, ent_addr(exp_idx)});
          check("req_data", dcStData_o, ent_data(exp_idx));
          check("req_size", {62'd0, dcStSize_o}, {62'd0, ent_size(exp_idx)});
          check("free_on_accept", {63'd0, stqFree_o}, 64'd1);
        end
      end else begin
        check("free_idle", {63'd0, stqFree_o}, 64'd0);
      end
    end
  end

  // Drive one cycle of inputs just after the edge, return at the sample point
  task automatic step(input int cnt, input bit rdy, input bit fence);
    @(posedge clk);
    #1;
    commitStCount_i = 3'(cnt);
    dcStReady_i     = rdy;
    fenceReq_i      = fence;
    for (int k = 0; k < cnt; k++) begin
      sb_q.push_back(w_ptr);
      w_ptr = w_ptr + 5'd1;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 80; k++) begin
      step(0, 1'b1, 1'b0);
      if (pendingCount_o == 6'd0 && !dcStValid_o) begin
        done = 1'b1;
        break;
      end
    end
    check("drain_done", {63'd0, done}, 64'd1);
  endtask

  initial begin
    reset = 1'b0;
    commitStCount_i = 3'd0;
    dcStReady_i = 1'b0;
    fenceReq_i = 1'b0;
    w_ptr = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {63'd0, dcStValid_o}, 64'd0);
    check("rst_pend", {58'd0, pendingCount_o}, 64'd0);
    check("rst_rdidx", {59'd0, stqRdIndex_o}, 64'd0);
    check("rst_ovf", {63'd0, drainOverflow_o}, 64'd0);
    check("rst_free", {63'd0, stqFree_o}, 64'd0);
    check("rst_fence", {63'd0, fenceDone_o}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Three commits: valid at t+2 for three back-to-back cycles
    step(3, 1'b1, 1'b0);
    check("t0_valid", {63'd0, dcStValid_o}, 64'd0);
    check("t0_pend", {58'd0, pendingCount_o}, 64'd0);
    step(0, 1'b1, 1'b0);
    check("t1_valid", {63'd0, dcStValid_o}, 64'd0);
    check("t1_pend", {58'd0, pendingCount_o}, 64'd3);
    for (int i = 0; i < 3; i++) begin
      step(0, 1'b1, 1'b0);
      check("burst_valid", {63'd0, dcStValid_o}, 64'd1);
      check("burst_idx", {59'd0, stqFreeIndex_o}, 64'(i));
    end
    step(0, 1'b1, 1'b0);
    check("burst_end_valid", {63'd0, dcStValid_o}, 64'd0);
    check("burst_end_pend", {58'd0, pendingCount_o}, 64'd0);

    // Back-pressure: payload holds while ready is low
    step(1, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1'b0, 1'b0);
      check("stall_valid", {63'd0, dcStValid_o}, 64'd1);
      check("stall_addr", {32'd0, dcStAddr_o}, {32'd0, ent_addr(5'd3)});
      check("stall_pend", {58'd0, pendingCount_o}, 64'd0);
    end
    step(0, 1'b1, 1'b0);
    check("stall_release_free", {63'd0, stqFree_o}, 64'd1);
    step(0, 1'b1, 1'b0);
    check("stall_after_valid", {63'd0, dcStValid_o}, 64'd0);

    // Pointer wrap: bring the head to 30, then drain 30,31,0,1
    while (w_ptr != 5'd30) begin
      step(((5'd30 - w_ptr) > 5'd4) ? 4 : int'(5'd30 - w_ptr), 1'b1, 1'b0);
    end
    drain();
    check("wrap_pre_ptr", {59'd0, stqRdIndex_o}, 64'd30);
    step(4, 1'b1, 1'b0);
    drain();
    check("wrap_post_ptr", {59'd0, stqRdIndex_o}, 64'd2);

    // Commit and load in the same cycle with a full stage
    step(3, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    check("same_pre_pend", {58'd0, pendingCount_o}, 64'd2);
    check("same_pre_valid", {63'd0, dcStValid_o}, 64'd1);
    step(4, 1'b1, 1'b0);
    check("same_free", {63'd0, stqFree_o}, 64'd1);
    step(0, 1'b1, 1'b0);
    check("same_post_pend", {58'd0, pendingCount_o}, 64'd5);
    check("same_post_valid", {63'd0, dcStValid_o}, 64'd1);
    drain();

    // Fence with one pending and one staged store
    step(2, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    check("fence_pre_pend", {58'd0, pendingCount_o}, 64'd1);
    step(0, 1'b1, 1'b1);
    check("fence_c0", {63'd0, fenceDone_o}, 64'd0);
    step(0, 1'b1, 1'b0);
    check("fence_c1", {63'd0, fenceDone_o}, 64'd0);
    step(0, 1'b1, 1'b0);
    check("fence_c2", {63'd0, fenceDone_o}, 64'd1);
    step(0, 1'b1, 1'b0);
    check("fence_c3", {63'd0, fenceDone_o}, 64'd0);

    // Fence with nothing outstanding completes the next cycle
    step(0, 1'b1, 1'b1);
    check("fence_idle_c0", {63'd0, fenceDone_o}, 64'd0);
    step(0, 1'b1, 1'b0);
    check("fence_idle_c1", {63'd0, fenceDone_o}, 64'd1);
    step(0, 1'b1, 1'b0);
    check("fence_idle_c2", {63'd0, fenceDone_o}, 64'd0);
    check("sb_empty_pre_ovf", 64'(sb_q.size()), 64'd0);

    // Overflow: 32 outstanding is legal, 36 is not
    for (int i = 0; i < 9; i++) begin
      step(4, 1'b0, 1'b0);
      check("ovf_not_yet", {63'd0, drainOverflow_o}, 64'd0);
    end
    step(0, 1'b0, 1'b0);
    check("ovf_set", {63'd0, drainOverflow_o}, 64'd1);
    step(0, 1'b0, 1'b0);
    check("ovf_sticky", {63'd0, drainOverflow_o}, 64'd1);

    // Asynchronous reset mid-stream, between clock edges
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("arst_valid", {63'd0, dcStValid_o}, 64'd0);
    check("arst_pend", {58'd0, pendingCount_o}, 64'd0);
    check("arst_rdidx", {59'd0, stqRdIndex_o}, 64'd0);
    check("arst_ovf", {63'd0, drainOverflow_o}, 64'd0);
    sb_q.delete();
    w_ptr = 5'd0;
    commitStCount_i = 3'd0;
    @(negedge clk);
    #1;
    reset = 1'b1;

    // Traffic resumes from index 0
    step(2, 1'b1, 1'b0);
    drain();
    check("sb_empty_end", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
